pipeline_ctr: RTL

PIPELINE_CTR -- requirements
Module: pipeline_ctr

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/pipeline_ctr_if.sv | 39 +++
 rtl/hazard_detect.sv | 27 ++
 rtl/pipeline_ctr.sv | 127 ++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// opcode constants and instruction field positions.
package pipeline_pkg;

    typedef enum logic {
        StRun    = 1'b0,
        StMdBusy = 1'b1
    } ctr_state_e;

    localparam logic [5:0] OP_LW = 6'b100011;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 26;
    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;

    localparam int unsigned MD_LAT_DEF = 4;

endpackage

// File: rtl/pipeline_ctr_if.sv
// Pipeline <-> hazard controller bundle: stage instructions and events in,
// stage enables/flushes and stall statistics out.
interface pipeline_ctr_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      id_inst;
    logic [31:0]      ex_inst;
    logic             ex_branch_taken;
    logic             md_start;
    logic             dmem_req;
    logic             dmem_ack;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             stall;
    logic             md_done;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_inst, ex_inst, ex_branch_taken, md_start, dmem_req, dmem_ack,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
        input  stall, md_done, stall_cycles
    );

    modport slave (
        input  id_inst, ex_inst, ex_branch_taken, md_start, dmem_req, dmem_ack,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
        output stall, md_done, stall_cycles
    );
endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a lw in EX whose destination is read by
// the instruction in ID.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [31:0] i_id_inst,
    input  logic [31:0] i_ex_inst,
    output logic        o_load_use
);
    logic [4:0] w_ex_rt;
    logic [4:0] w_id_rs;
    logic [4:0] w_id_rt;
    logic       w_ex_is_lw;
    logic       w_unused_bits;

    assign w_ex_rt    = i_ex_inst[RT_MSB:RT_LSB];
    assign w_id_rs    = i_id_inst[RS_MSB:RS_LSB];
    assign w_id_rt    = i_id_inst[RT_MSB:RT_LSB];
    assign w_ex_is_lw = (i_ex_inst[OP_MSB:OP_LSB] == OP_LW);

    // $0 is hardwired zero, so a load into it never creates a dependency
    assign o_load_use = w_ex_is_lw && (w_ex_rt != 5'd0) &&
                        ((w_ex_rt == w_id_rs) || (w_ex_rt == w_id_rt));

    assign w_unused_bits = ^{i_id_inst[OP_MSB:OP_LSB], i_id_inst[15:0],
                             i_ex_inst[RS_MSB:RS_LSB], i_ex_inst[15:0]};
endmodule

// File: rtl/pipeline_ctr.sv
// Five-stage pipeline hazard controller: memory wait, multi-cycle mul/div
// freeze, taken-branch flush, load-use bubble and a saturating stall counter.
module pipeline_ctr
    import pipeline_pkg::*;
#(
    parameter int unsigned MD_LAT = MD_LAT_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctr_if.slave  bus
);
    localparam logic [3:0] MdInit = 4'(MD_LAT - 1);

    ctr_state_e       r_state;
    ctr_state_e       w_state_d;
    logic [3:0]       r_md_cnt;
    logic [3:0]       w_md_cnt_d;
    logic             r_br_pend;
    logic             w_br_pend_d;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_load_use;
    logic w_mem_wait;
    logic w_branch;
    logic w_stall;

    hazard_detect u_hazard_detect (
        .i_id_inst  (bus.id_inst),
        .i_ex_inst  (bus.ex_inst),
        .o_load_use (w_load_use)
    );

    assign w_mem_wait = bus.dmem_req & ~bus.dmem_ack;
    // A branch seen while memory stalls is remembered until its flush can go out
    assign w_branch   = bus.ex_branch_taken | r_br_pend;

    always_comb begin
        w_state_d   = r_state;
        w_md_cnt_d  = r_md_cnt;
        w_br_pend_d = r_br_pend;
        unique case (r_state)
            StRun: begin
                w_br_pend_d = w_branch & w_mem_wait;
                if (bus.md_start) begin
                    w_state_d  = StMdBusy;
                    w_md_cnt_d = MdInit;
                end
            end
            StMdBusy: begin
                w_md_cnt_d = r_md_cnt - 4'd1;
                if (r_md_cnt == 4'd1) begin
                    w_state_d = StRun;
                end
            end
            default: w_state_d = StRun;
        endcase
    end

    always_comb begin
        bus.pc_en        = 1'b1;
        bus.if_id_en     = 1'b1;
        bus.id_ex_en     = 1'b1;
        bus.ex_mem_en    = 1'b1;
        bus.mem_wb_en    = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        bus.ex_mem_flush = 1'b0;
        bus.mem_wb_flush = 1'b0;
        bus.md_done      = 1'b0;
        if (rst) begin
            bus.pc_en        = 1'b0;
            bus.if_id_en     = 1'b0;
            bus.id_ex_en     = 1'b0;
            bus.ex_mem_en    = 1'b0;
            bus.mem_wb_en    = 1'b0;
            bus.if_id_flush  = 1'b1;
            bus.id_ex_flush  = 1'b1;
            bus.ex_mem_flush = 1'b1;
            bus.mem_wb_flush = 1'b1;
        end else begin
            // md_done tracks the freeze counter even while memory stalls
            bus.md_done = (r_state == StMdBusy) && (r_md_cnt == 4'd1);
            if (w_mem_wait) begin
                bus.pc_en        = 1'b0;
                bus.if_id_en     = 1'b0;
                bus.id_ex_en     = 1'b0;
                bus.ex_mem_en    = 1'b0;
                bus.mem_wb_en    = 1'b0;
                bus.mem_wb_flush = 1'b1;
            end else if ((r_state == StMdBusy) || bus.md_start) begin
                bus.pc_en        = 1'b0;
                bus.if_id_en     = 1'b0;
                bus.id_ex_en     = 1'b0;
                bus.ex_mem_flush = 1'b1;
            end else if (w_branch) begin
                bus.if_id_flush = 1'b1;
                bus.id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                bus.pc_en       = 1'b0;
                bus.if_id_en    = 1'b0;
                bus.id_ex_flush = 1'b1;
            end
        end
    end

    assign w_stall = ~rst & ~(bus.pc_en & bus.if_id_en & bus.id_ex_en &
                              bus.ex_mem_en & bus.mem_wb_en);
    assign bus.stall        = w_stall;
    assign bus.stall_cycles = r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= StRun;
            r_md_cnt       <= 4'd0;
            r_br_pend      <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state   <= w_state_d;
            r_md_cnt  <= w_md_cnt_d;
            r_br_pend <= w_br_pend_d;
            if (w_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end
endmodule
